// File: rtl/split_element.sv
// Splits one tagged partial-CRC beat stream onto up/mid/low segment lanes and
// polices sop/eop framing and packet_num sequencing. Optional counters: SPLIT_ELEMENT_STATS_EN.
module split_element #(
  parameter int DW  = 32,
  parameter int PNW = 4,
  parameter int ZNW = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_sop,
  input  logic           in_eop,
  input  logic           in_dval,
  input  logic           in_sop_lane,
  input  logic           in_eop_lane,
  input  logic [PNW-1:0] in_packet_num,
  input  logic [ZNW-1:0] in_zero_num,
  input  logic [DW-1:0]  in_dout,
  output logic           up_sop_out,
  output logic           up_eop_out,
  output logic           up_dval_out,
  output logic [PNW-1:0] up_packet_num_out,
  output logic [ZNW-1:0] up_zero_num_out,
  output logic [DW-1:0]  up_dout_out,
  output logic           mid_sop_out,
  output logic           mid_eop_out,
  output logic           mid_dval_out,
  output logic [PNW-1:0] mid_packet_num_out,
  output logic [ZNW-1:0] mid_zero_num_out,
  output logic [DW-1:0]  mid_dout_out,
  output logic           low_sop_out,
  output logic           low_eop_out,
  output logic           low_dval_out,
  output logic [PNW-1:0] low_packet_num_out,
  output logic [ZNW-1:0] low_zero_num_out,
  output logic [DW-1:0]  low_dout_out,
`ifdef SPLIT_ELEMENT_STATS_EN
  output logic [15:0]    pkt_cnt,
  output logic [15:0]    err_cnt,
`endif
  output logic [2:0]     err_pulse,
  output logic           err_sticky
);

  typedef enum logic [0:0] {IDLE, IN_PKT} state_t;

  state_t         state, state_nxt;
  logic [PNW-1:0] expected_num, expected_nxt;
  logic           first_pkt, first_nxt;
  logic           fwd;
  logic [2:0]     err_c;

  // Stage-1 registered beat
  logic           s1_fwd, s1_sop, s1_eop, s1_sop_lane, s1_eop_lane;
  logic [PNW-1:0] s1_num;
  logic [ZNW-1:0] s1_zn;
  logic [DW-1:0]  s1_dout;
  logic [2:0]     s1_err;

  always_comb begin
    state_nxt    = state;
    expected_nxt = expected_num;
    first_nxt    = first_pkt;
    fwd          = 1'b0;
    err_c        = '0;
    if (in_dval) begin
      unique case (state)
        IDLE: begin
          if (!in_sop) begin
            err_c[0] = 1'b1;
          end else begin
            fwd = 1'b1;
            if (!in_eop) state_nxt = IN_PKT;
          end
        end
        IN_PKT: begin
          fwd = 1'b1;
          if (in_sop) err_c[1] = 1'b1;
          if (in_eop) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
      // Resync on every forwarded sop, whether or not it matched
      if (fwd && in_sop) begin
        if (!first_pkt && (in_packet_num != expected_num)) err_c[2] = 1'b1;
        expected_nxt = in_packet_num + PNW'(1);
        first_nxt    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      expected_num <= '0;
      first_pkt    <= 1'b1;
      s1_fwd       <= 1'b0;
      s1_sop       <= 1'b0;
      s1_eop       <= 1'b0;
      s1_sop_lane  <= 1'b0;
      s1_eop_lane  <= 1'b0;
      s1_num       <= '0;
      s1_zn        <= '0;
      s1_dout      <= '0;
      s1_err       <= '0;
    end else begin
      state        <= state_nxt;
      expected_num <= expected_nxt;
      first_pkt    <= first_nxt;
      s1_fwd       <= fwd;
      s1_sop       <= in_sop;
      s1_eop       <= in_eop;
      s1_sop_lane  <= in_sop_lane;
      s1_eop_lane  <= in_eop_lane;
      s1_num       <= in_packet_num;
      s1_zn        <= in_zero_num;
      s1_dout      <= in_dout;
      s1_err       <= err_c;
    end
  end

  logic up_sop_c, mid_sop_c, mid_eop_c, low_eop_c;

  always_comb begin
    up_sop_c  = s1_fwd & s1_sop & s1_sop_lane;
    mid_sop_c = s1_fwd & s1_sop & ~s1_sop_lane;
    low_eop_c = s1_fwd & s1_eop & s1_eop_lane;
    mid_eop_c = s1_fwd & s1_eop & ~s1_eop_lane;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_sop_out         <= 1'b0;
      up_eop_out         <= 1'b0;
      up_dval_out        <= 1'b0;
      up_packet_num_out  <= '0;
      up_zero_num_out    <= '0;
      up_dout_out        <= '0;
      mid_sop_out        <= 1'b0;
      mid_eop_out        <= 1'b0;
      mid_dval_out       <= 1'b0;
      mid_packet_num_out <= '0;
      mid_zero_num_out   <= '0;
      mid_dout_out       <= '0;
      low_sop_out        <= 1'b0;
      low_eop_out        <= 1'b0;
      low_dval_out       <= 1'b0;
      low_packet_num_out <= '0;
      low_zero_num_out   <= '0;
      low_dout_out       <= '0;
      err_pulse          <= '0;
      err_sticky         <= 1'b0;
    end else begin
      up_sop_out         <= up_sop_c;
      up_eop_out         <= 1'b0;
      up_dval_out        <= up_sop_c;
      up_packet_num_out  <= s1_fwd ? s1_num : '0;
      up_zero_num_out    <= '0;
      up_dout_out        <= up_sop_c ? s1_dout : '0;
      mid_sop_out        <= mid_sop_c;
      mid_eop_out        <= mid_eop_c;
      mid_dval_out       <= s1_fwd;
      mid_packet_num_out <= s1_fwd ? s1_num : '0;
      mid_zero_num_out   <= mid_eop_c ? s1_zn : '0;
      mid_dout_out       <= (s1_fwd && !up_sop_c && !low_eop_c) ? s1_dout : '0;
      low_sop_out        <= 1'b0;
      low_eop_out        <= low_eop_c;
      low_dval_out       <= low_eop_c;
      low_packet_num_out <= s1_fwd ? s1_num : '0;
      low_zero_num_out   <= low_eop_c ? s1_zn : '0;
      low_dout_out       <= (low_eop_c && !up_sop_c) ? s1_dout : '0;
      err_pulse          <= s1_err;
      err_sticky         <= err_sticky | (|s1_err);
    end
  end

`ifdef SPLIT_ELEMENT_STATS_EN
  logic [1:0]  err_pop;
  logic [16:0] err_sum;

  always_comb begin
    err_pop = 2'(s1_err[0]) + 2'(s1_err[1]) + 2'(s1_err[2]);
    err_sum = {1'b0, err_cnt} + 17'(err_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (s1_fwd && s1_sop && (pkt_cnt != 16'hFFFF)) pkt_cnt <= pkt_cnt + 16'd1;
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_split_element.sv
// Randomized and directed bench for split_element against a lane-indexed reference model.
module tb_split_element;

  localparam int DW = 32, PNW = 4, ZNW = 12;
  localparam int LW = 3 + PNW + ZNW + DW;
  localparam int OW = 3 * LW + 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_sop = 1'b0, in_eop = 1'b0, in_dval = 1'b0, in_sop_lane = 1'b0, in_eop_lane = 1'b0;
  logic [PNW-1:0] in_packet_num = '0;
  logic [ZNW-1:0] in_zero_num = '0;
  logic [DW-1:0]  in_dout = '0;

  logic up_sop_out, up_eop_out, up_dval_out, mid_sop_out, mid_eop_out, mid_dval_out;
  logic low_sop_out, low_eop_out, low_dval_out, err_sticky;
  logic [PNW-1:0] up_packet_num_out, mid_packet_num_out, low_packet_num_out;
  logic [ZNW-1:0] up_zero_num_out, mid_zero_num_out, low_zero_num_out;
  logic [DW-1:0]  up_dout_out, mid_dout_out, low_dout_out;
  logic [2:0]     err_pulse;
`ifdef SPLIT_ELEMENT_STATS_EN
  logic [15:0]    pkt_cnt, err_cnt;
`endif

  split_element #(.DW(DW), .PNW(PNW), .ZNW(ZNW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_sop(in_sop), .in_eop(in_eop), .in_dval(in_dval),
    .in_sop_lane(in_sop_lane), .in_eop_lane(in_eop_lane),
    .in_packet_num(in_packet_num), .in_zero_num(in_zero_num), .in_dout(in_dout),
    .up_sop_out(up_sop_out), .up_eop_out(up_eop_out), .up_dval_out(up_dval_out),
    .up_packet_num_out(up_packet_num_out), .up_zero_num_out(up_zero_num_out), .up_dout_out(up_dout_out),
    .mid_sop_out(mid_sop_out), .mid_eop_out(mid_eop_out), .mid_dval_out(mid_dval_out),
    .mid_packet_num_out(mid_packet_num_out), .mid_zero_num_out(mid_zero_num_out), .mid_dout_out(mid_dout_out),
    .low_sop_out(low_sop_out), .low_eop_out(low_eop_out), .low_dval_out(low_dval_out),
    .low_packet_num_out(low_packet_num_out), .low_zero_num_out(low_zero_num_out), .low_dout_out(low_dout_out),
`ifdef SPLIT_ELEMENT_STATS_EN
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt),
`endif
    .err_pulse(err_pulse), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  logic [OW-1:0] obs;
  assign obs = {up_sop_out, up_eop_out, up_dval_out, up_packet_num_out, up_zero_num_out, up_dout_out,
                mid_sop_out, mid_eop_out, mid_dval_out, mid_packet_num_out, mid_zero_num_out, mid_dout_out,
                low_sop_out, low_eop_out, low_dval_out, low_packet_num_out, low_zero_num_out, low_dout_out,
                err_pulse, err_sticky};

  // Reference model: packet framing state and sequencing in plain terms
  bit            m_in_pkt;
  bit            m_first;
  int unsigned   m_exp;
  bit            m_sticky;
  logic [OW-1:0] exp_q[$];

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic check(input string tag, input logic [OW-1:0] o, input logic [OW-1:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, o, e);
  endtask

  task automatic model_reset();
    m_in_pkt = 0;
    m_first  = 1;
    m_exp    = 0;
    m_sticky = 0;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  // Lanes indexed 0=up, 1=mid, 2=low
  function automatic logic [OW-1:0] model_beat(input bit dv, sop, eop, sl, el,
                                                input int unsigned num, input int unsigned zn,
                                                input logic [DW-1:0] d);
    logic [LW-1:0] lane[3];
    bit            l_sop[3], l_eop[3], l_dv[3];
    logic [ZNW-1:0] l_zn[3];
    logic [DW-1:0] l_d[3];
    logic [2:0]    err = '0;
    bit            forwarded = 0;
    int            sop_idx = -1, eop_idx = -1, data_idx;
    for (int i = 0; i < 3; i++) begin
      l_sop[i] = 0; l_eop[i] = 0; l_dv[i] = 0; l_zn[i] = '0; l_d[i] = '0;
    end
    if (dv) begin
      if (!m_in_pkt && !sop) err[0] = 1;
      else begin
        forwarded = 1;
        if (m_in_pkt && sop) err[1] = 1;
        if (sop) begin
          if (!m_first && num != m_exp) err[2] = 1;
          m_exp   = (num + 1) % (1 << PNW);
          m_first = 0;
        end
        m_in_pkt = !eop;
      end
    end
    if (forwarded) begin
      if (sop) sop_idx = sl ? 0 : 1;
      if (eop) eop_idx = el ? 2 : 1;
      data_idx = (sop_idx == 0) ? 0 : (eop_idx == 2) ? 2 : 1;
      l_dv[1] = 1;
      if (sop_idx >= 0) begin l_sop[sop_idx] = 1; l_dv[sop_idx] = 1; end
      if (eop_idx >= 0) begin l_eop[eop_idx] = 1; l_dv[eop_idx] = 1; l_zn[eop_idx] = ZNW'(zn); end
      l_d[data_idx] = d;
    end
    for (int i = 0; i < 3; i++)
      lane[i] = {l_sop[i], l_eop[i], l_dv[i], forwarded ? PNW'(num) : PNW'(0), l_zn[i], l_d[i]};
    m_sticky = m_sticky | (|err);
    return {lane[0], lane[1], lane[2], err, m_sticky};
  endfunction

  task automatic beat(input string tag, input bit dv, sop, eop, sl, el,
                      input int unsigned num, input int unsigned zn, input logic [DW-1:0] d);
    @(negedge clk);
    in_dval = dv; in_sop = sop; in_eop = eop; in_sop_lane = sl; in_eop_lane = el;
    in_packet_num = PNW'(num); in_zero_num = ZNW'(zn); in_dout = d;
    exp_q.push_back(model_beat(dv, sop, eop, sl, el, num, zn, d));
    @(posedge clk);
    #1;
    check(tag, obs, exp_q.pop_front());
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) beat("idle", 0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    in_dval = 0; in_sop = 0; in_eop = 0;
    rst_n = 0;
    #1;
    check("reset_async", obs, '0);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", obs, '0);
    rst_n = 1;

    // Single-beat packet
    beat("single", 1, 1, 1, 1, 1, 3, 12'h00A, 32'hDEADBEEF);
    beat("single_out", 0, 0, 0, 0, 0, 0, 0, '0);
    idle(1);

    // Three-beat packet on mid lanes
    beat("p3_b1", 1, 1, 0, 0, 0, 5, 0, 32'd1);
    beat("p3_b2", 1, 0, 0, 0, 0, 5, 0, 32'd2);
    beat("p3_b3", 1, 0, 1, 0, 0, 5, 12'h123, 32'd3);
    idle(2);

    // Orphan beat
    beat("orphan", 1, 0, 1, 0, 1, 6, 12'h005, 32'hCAFE0001);
    idle(2);

    // Duplicate sop
    beat("dup_b1", 1, 1, 0, 1, 0, 2, 0, 32'hA1);
    beat("dup_b2", 1, 0, 0, 0, 0, 2, 0, 32'hA2);
    beat("dup_b3", 1, 1, 0, 0, 0, 3, 0, 32'hA3);
    beat("dup_b4", 1, 0, 1, 0, 1, 3, 12'h7, 32'hA4);
    beat("dup_after", 1, 0, 0, 0, 0, 4, 0, 32'hA5);
    idle(2);

    // Sequence with wrap and one gap
    async_reset();
    beat("seq14", 1, 1, 1, 0, 0, 14, 1, 32'h14);
    beat("seq15", 1, 1, 1, 1, 0, 15, 2, 32'h15);
    beat("seq0",  1, 1, 1, 1, 1, 0, 3, 32'h00);
    beat("seq2",  1, 1, 1, 0, 1, 2, 4, 32'h02);
    beat("seq3",  1, 1, 1, 1, 1, 3, 5, 32'h03);
    idle(2);

    // Reset mid-packet
    beat("rst_b1", 1, 1, 0, 1, 0, 9, 0, 32'hB1);
    beat("rst_b2", 1, 0, 0, 0, 0, 9, 0, 32'hB2);
    async_reset();
    beat("rst_eop", 1, 0, 1, 0, 0, 9, 12'h3, 32'hB3);
    beat("rst_sop", 1, 1, 1, 0, 1, 11, 12'h4, 32'hB4);
    idle(2);

    // Randomized traffic biased toward legal framing
    for (int i = 0; i < 400; i++) begin
      bit dv, sop, eop;
      int unsigned num;
      dv   = ($urandom_range(0, 4) != 0);
      sop  = m_in_pkt ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      eop  = ($urandom_range(0, 2) == 0);
      num  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : m_exp;
      beat("random", dv, sop, eop, 1'($urandom), 1'($urandom), num,
           $urandom_range(0, 4095), $urandom);
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
